spi_ctrl_master: RTL and testbench
==================================

SPI_CTRL_MASTER -- requirements
Module: spi_ctrl_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCK half-period; legal range is 1..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports tx_valid (input, 1), tx_ready (output, 1) and tx_data (input, 8), forming the byte-to-send handshake.
REQ-005 SHALL have port tx_sel, input, 2 bits, selecting the target: 0 conf_data0, 1 spi_ss2, 2 spi_ss3, 3 no select line.
REQ-006 SHALL have port tx_last, input, 1 bit: release the select after this byte.
REQ-007 SHALL have port abort, input, 1 bit: terminate the current transfer immediately.
REQ-008 SHALL have ports rx_valid (output, 1) and rx_data (output, 8): the received byte, flagged by a 1-cycle strobe.
REQ-009 SHALL have ports spi_sck (output, 1), spi_mosi (output, 1, driving the core SPI_DI) and spi_miso (input, 1, from the core SPI_DO).
REQ-010 SHALL have ports conf_data0, spi_ss2 and spi_ss3, outputs, 1 bit each, active-low selects.

Function
REQ-011 SHALL implement SPI mode 0 (SCK idle low), MSB first, with MOSI changing only while SCK is low.
REQ-012 SHALL use states IDLE, LOW, HIGH, TAIL, SEL and GAP, each held for CLK_DIV cycles except IDLE and SEL.
REQ-013 SHALL hold tx_ready=1 only in IDLE and SEL; a byte is accepted on the edge where tx_valid && tx_ready.
REQ-014 On accept from IDLE, SHALL latch tx_sel, tx_data and tx_last, drive the selected line low, put bit7 on MOSI and enter LOW.
REQ-015 On accept from SEL, SHALL ignore tx_sel, keep the latched select asserted, latch tx_data and tx_last, and enter LOW.
REQ-016 The sequence SHALL be LOW -> HIGH -> LOW ... 8 HIGH halves -> TAIL, with the next bit shifted out on each HIGH->LOW transition.
REQ-017 SHALL register spi_miso on the clk edge that drives spi_sck 1 and shift it into rx_data LSB-first into the shift register, so that after 8 samples the first sample is the MSB.
REQ-018 At the end of TAIL, SHALL pulse rx_valid for exactly 1 cycle, with rx_data stable until the next pulse.
REQ-019 rx_valid SHALL assert exactly 17*CLK_DIV cycles after the accepting edge.
REQ-020 After TAIL, SHALL go to GAP (all selects high, SCK 0) if tx_last=1, otherwise to SEL (select held low, SCK 0).
REQ-021 GAP SHALL last CLK_DIV cycles and then return to IDLE, guaranteeing a minimum select-inactive time.
REQ-022 With tx_sel=3, SHALL clock SCK and MOSI normally while asserting no select.
REQ-023 abort=1 in any state other than IDLE SHALL, on the next edge, raise all selects, set SCK 0, discard the partial byte (no rx_valid) and enter GAP.
REQ-024 abort SHALL take priority over a simultaneous accept, and abort in IDLE SHALL have no effect.
REQ-025 tx_valid with tx_ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-026 The divider counter SHALL count CLK_DIV-1 down to 0 and reload on every state change; it SHALL NOT wrap into the next state early.

Reset
REQ-027 Reset SHALL force state IDLE, spi_sck 0, spi_mosi 0, and conf_data0, spi_ss2 and spi_ss3 all 1.
REQ-028 Reset SHALL force tx_ready 1 in the first cycle after reset is released.
REQ-029 Reset SHALL force rx_valid 0 and rx_data 0.
REQ-030 Reset asserted mid-byte SHALL discard the byte with no rx_valid, and outputs SHALL show reset values after the next edge.

Structure
REQ-031 The package spi_ctrl_pkg SHALL hold the state enum, the tx_sel encodings (SEL_CONF=0, SEL_SS2=1, SEL_SS3=2, SEL_NONE=3) and the CLK_DIV width constant.
REQ-032 SHALL contain one sub-module, spi_half_tick, implementing the loadable half-period counter with a 1-cycle expiry output.

Verification
REQ-033 CLK_DIV=4, tx_sel=0, tx_data=0xA5, tx_last=1, slave returns 0x3C -> conf_data0 low; MOSI bits 1,0,1,0,0,1,0,1; rx_valid 68 cycles after accept with rx_data=0x3C; conf_data0 high for ≥4 cycles before tx_ready.
REQ-034 Two bytes 0x14 then 0xFF on tx_sel=1 with tx_last=0 then 1 -> spi_ss2 low continuously across both bytes, 16 SCK rising edges in total, two rx_valid pulses 68 cycles apart from their accepts.
REQ-035 abort asserted after the 3rd SCK rising edge -> all selects high and SCK 0 on the next edge, no rx_valid, GAP of 4 cycles, then IDLE.
REQ-036 reset asserted during HIGH of bit 5 -> the next cycle shows SCK=0, selects=111, rx_valid=0, tx_ready=1 after release; a following byte 0x81 completes correctly.
REQ-037 CLK_DIV=1, tx_sel=3, 0x5A looped MOSI->MISO -> no select asserted, rx_data=0x5A after 17 cycles.
REQ-038 tx_valid held high while tx_ready=0 -> exactly one byte is transferred per handshake, with no duplicate or dropped byte.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg: shared types and constants for the SPI control master.
//   state_t   : controller state encoding
//   SEL_*     : tx_sel encodings for the target select line
//   DIV_W     : width of the half-period divider counter (CLK_DIV <= 255)
//   sel_lines : maps a tx_sel code to the active-low {ss3, ss2, conf} lines
package spi_ctrl_pkg;

  localparam int DIV_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_TAIL,
    ST_SEL,
    ST_GAP
  } state_t;

  localparam logic [1:0] SEL_CONF = 2'd0;
  localparam logic [1:0] SEL_SS2  = 2'd1;
  localparam logic [1:0] SEL_SS3  = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  // Returns {spi_ss3, spi_ss2, conf_data0}, active low; SEL_NONE asserts nothing.
  function automatic logic [2:0] sel_lines(input logic [1:0] sel);
    case (sel)
      SEL_CONF: return 3'b110;
      SEL_SS2:  return 3'b101;
      SEL_SS3:  return 3'b011;
      default:  return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/spi_half_tick.sv
// spi_half_tick: loadable down-counter timing one SCK half-period.
//   clk, reset : clock and synchronous active-high reset
//   load       : reload the counter with CLK_DIV-1 (asserted on every state change)
//   expire     : high in the last cycle of the half-period (count reached 0)
module spi_half_tick
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expire
);

  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] count;

  // Counts down and parks at 0; only an explicit load starts a new period,
  // so the count never wraps into the following state on its own.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/spi_ctrl_master.sv
// spi_ctrl_master: byte-oriented SPI mode-0 master with three active-low selects.
//   clk, reset          : clock and synchronous active-high reset
//   tx_valid/tx_ready   : byte handshake; tx_data byte, tx_sel target, tx_last release select after
//   abort               : drop the current transfer and go through the select-inactive gap
//   rx_valid/rx_data    : received byte with a 1-cycle strobe
//   spi_sck/mosi/miso   : SPI bus, MSB first, SCK idle low
//   conf_data0/ss2/ss3  : active-low select lines
module spi_ctrl_master
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic [1:0] tx_sel,
  input  logic       tx_last,
  input  logic       abort,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       conf_data0,
  output logic       spi_ss2,
  output logic       spi_ss3
);

  state_t     state;
  logic [2:0] sel_n;
  logic [6:0] tx_shift;
  logic [7:0] rx_shift;
  logic [2:0] bit_cnt;
  logic       last_q;
  logic       expire;
  logic       timed;
  logic       abort_act;
  logic       accept;
  logic       load;

  // Abort is ignored in IDLE and beats a same-cycle accept everywhere else.
  assign abort_act = abort && (state != ST_IDLE);
  assign accept    = tx_valid && tx_ready && !abort_act;
  assign timed     = (state == ST_LOW) || (state == ST_HIGH) ||
                     (state == ST_TAIL) || (state == ST_GAP);
  assign load      = accept || abort_act || (timed && expire);

  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .expire (expire)
  );

  assign {spi_ss3, spi_ss2, conf_data0} = sel_n;

  // Single registered FSM: every output is updated on the same edge that
  // changes state, so the bus pins never glitch between states.
  always_ff @(posedge clk) begin
    rx_valid <= 1'b0;
    if (reset) begin
      state    <= ST_IDLE;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
      sel_n    <= 3'b111;
      tx_ready <= 1'b1;
      rx_data  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      last_q   <= 1'b0;
    end else if (abort_act) begin
      state    <= ST_GAP;
      spi_sck  <= 1'b0;
      sel_n    <= 3'b111;
      tx_ready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_SEL: begin
          if (accept) begin
            // A continuation byte from SEL keeps the select already driven.
            if (state == ST_IDLE) begin
              sel_n <= sel_lines(tx_sel);
            end
            spi_mosi <= tx_data[7];
            tx_shift <= tx_data[6:0];
            last_q   <= tx_last;
            bit_cnt  <= '0;
            tx_ready <= 1'b0;
            state    <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (expire) begin
            // MISO enters at the LSB, so the first sample ends up as the MSB.
            spi_sck  <= 1'b1;
            rx_shift <= {rx_shift[6:0], spi_miso};
            state    <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (expire) begin
            spi_sck <= 1'b0;
            if (bit_cnt == 3'd7) begin
              state <= ST_TAIL;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              spi_mosi <= tx_shift[6];
              tx_shift <= {tx_shift[5:0], 1'b0};
              state    <= ST_LOW;
            end
          end
        end
        ST_TAIL: begin
          if (expire) begin
            rx_valid <= 1'b1;
            rx_data  <= rx_shift;
            if (last_q) begin
              sel_n <= 3'b111;
              state <= ST_GAP;
            end else begin
              tx_ready <= 1'b1;
              state    <= ST_SEL;
            end
          end
        end
        ST_GAP: begin
          if (expire) begin
            tx_ready <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ctrl_master.sv
// tb_spi_ctrl_master: randomized scoreboard bench for spi_ctrl_master.
// A behavioural SPI slave returns a chosen byte on MISO; each accepted byte
// pushes its expected rx byte and accept time, and a monitor pops on rx_valid.
// A second instance with CLK_DIV=1 and MOSI looped to MISO covers the fast divider.
module tb_spi_ctrl_master;

  localparam int DIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       tx_valid, tx_last, abort;
  logic [7:0] tx_data;
  logic [1:0] tx_sel;
  logic       tx_ready, rx_valid, spi_sck, spi_mosi, spi_miso;
  logic [7:0] rx_data;
  logic       conf_data0, spi_ss2, spi_ss3;

  logic       tx_valid1, tx_last1;
  logic [7:0] tx_data1;
  logic [1:0] tx_sel1;
  logic       tx_ready1, rx_valid1, spi_sck1, spi_mosi1;
  logic [7:0] rx_data1;
  logic       conf_data0_1, spi_ss2_1, spi_ss3_1;

  spi_ctrl_master #(.CLK_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_sel(tx_sel), .tx_last(tx_last), .abort(abort),
    .rx_valid(rx_valid), .rx_data(rx_data), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .conf_data0(conf_data0),
    .spi_ss2(spi_ss2), .spi_ss3(spi_ss3)
  );

  spi_ctrl_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .tx_data(tx_data1), .tx_sel(tx_sel1), .tx_last(tx_last1), .abort(1'b0),
    .rx_valid(rx_valid1), .rx_data(rx_data1), .spi_sck(spi_sck1),
    .spi_mosi(spi_mosi1), .spi_miso(spi_mosi1), .conf_data0(conf_data0_1),
    .spi_ss2(spi_ss2_1), .spi_ss3(spi_ss3_1)
  );

  typedef struct {
    logic [7:0] rx;
    int         accept_edge;
  } exp_t;

  exp_t       sb_q[$];
  int         total = 0;
  int         bad = 0;
  int         cycle_count = 0;
  int         sck_rise = 0;
  int         sck_fall = 0;
  int         base_rise = 0;
  int         base_fall = 0;
  int         rise_k;
  int         ss2_high = 0;
  logic       watch_ss2 = 1'b0;
  logic       prev_sck = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] exp_mosi = 8'h00;
  logic [7:0] mosi_acc = 8'h00;
  logic [2:0] exp_sel_lines = 3'b111;
  logic       chain_open = 1'b0;
  exp_t       mon_e;

  always @(posedge clk) cycle_count <= cycle_count + 1;

  // Slave drives bit (7 - falls since accept), MSB first, changing only after SCK falls.
  assign spi_miso = ((sck_fall - base_fall) < 8) ? slave_byte[3'(7 - (sck_fall - base_fall))] : 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Active-low {ss3, ss2, conf} the target code should produce.
  function automatic logic [2:0] sel_model(input logic [1:0] sel);
    case (sel)
      2'd0:    return 3'b110;
      2'd1:    return 3'b101;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  // Bus monitor and scoreboard checker, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (spi_sck === 1'b1 && prev_sck === 1'b0) begin
      rise_k = sck_rise - base_rise;
      if (rise_k >= 0 && rise_k < 8) begin
        mosi_acc[7 - rise_k] = spi_mosi;
        checkOutput("select_lines", {29'd0, spi_ss3, spi_ss2, conf_data0}, {29'd0, exp_sel_lines});
        if (rise_k == 7) checkOutput("mosi_byte", {24'd0, mosi_acc}, {24'd0, exp_mosi});
      end
      sck_rise++;
    end
    if (spi_sck === 1'b0 && prev_sck === 1'b1) sck_fall++;
    prev_sck = spi_sck;
    if (watch_ss2 && spi_ss2 !== 1'b0) ss2_high++;
    if (rx_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_rx_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("rx_data", {24'd0, rx_data}, {24'd0, mon_e.rx});
        checkOutput("rx_latency", cycle_count - mon_e.accept_edge, 17 * DIV);
      end
    end
  end

  // Offers one byte, records the expectation for the edge that accepts it,
  // then keeps tx_valid high for up to 'hold' cycles while tx_ready is low.
  task automatic applyStimulus(input logic [1:0] sel, input logic [7:0] data, input logic last,
                               input logic [7:0] ret, input int hold);
    int   waits;
    exp_t e;
    @(negedge clk);
    tx_sel = sel; tx_data = data; tx_last = last; tx_valid = 1'b1;
    waits = 0;
    while (tx_ready !== 1'b1 && waits < 400) begin
      @(negedge clk);
      waits++;
    end
    if (tx_ready !== 1'b1) begin
      checkOutput("tx_ready_timeout", 32'd0, 32'd1);
      tx_valid = 1'b0;
      return;
    end
    if (!chain_open) exp_sel_lines = sel_model(sel);
    chain_open = !last;
    slave_byte = ret;
    exp_mosi   = data;
    base_fall  = sck_fall;
    base_rise  = sck_rise;
    e.rx = ret;
    e.accept_edge = cycle_count + 1;
    sb_q.push_back(e);
    @(negedge clk);
    for (int i = 0; i < hold; i++) begin
      if (tx_ready === 1'b1) break;
      @(negedge clk);
    end
    tx_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb_q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checkOutput("drain_timeout", sb_q.size(), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic waitRises(input int target);
    int n = 0;
    while ((sck_rise < target || spi_sck !== 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) checkOutput("sck_rise_timeout", sck_rise, target);
  endtask

  // Loopback byte on the CLK_DIV=1 instance: no select, rx equals tx after 17 cycles.
  task automatic loopTest(input logic [7:0] d);
    int start, n;
    @(negedge clk);
    tx_sel1 = 2'd3; tx_data1 = d; tx_last1 = 1'b1; tx_valid1 = 1'b1;
    n = 0;
    while (tx_ready1 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    start = cycle_count + 1;
    @(negedge clk);
    tx_valid1 = 1'b0;
    checkOutput("fast_selects", {29'd0, spi_ss3_1, spi_ss2_1, conf_data0_1}, 32'h7);
    n = 0;
    while (rx_valid1 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("fast_latency", cycle_count - start, 32'd17);
    checkOutput("fast_rx_data", {24'd0, rx_data1}, {24'd0, d});
    checkOutput("fast_sck_idle", {31'd0, spi_sck1}, 32'd0);
  endtask

  initial begin
    int g, rise0;
    logic last_r;
    reset = 1'b1; abort = 1'b0;
    tx_valid = 1'b0; tx_sel = 2'd0; tx_data = 8'h00; tx_last = 1'b0;
    tx_valid1 = 1'b0; tx_sel1 = 2'd3; tx_data1 = 8'h00; tx_last1 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("reset_sck", {31'd0, spi_sck}, 32'd0);
    checkOutput("reset_mosi", {31'd0, spi_mosi}, 32'd0);
    checkOutput("reset_selects", {29'd0, spi_ss3, spi_ss2, conf_data0}, 32'h7);
    checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("reset_rx_data", {24'd0, rx_data}, 32'd0);

    $display("[TB] single byte 0xA5 to conf_data0");
    applyStimulus(2'd0, 8'hA5, 1'b1, 8'h3C, 0);
    g = 0;
    while (rx_valid !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    g = 0;
    while (tx_ready !== 1'b1 && g < 20) begin
      if (conf_data0 === 1'b1) g++;
      @(negedge clk);
    end
    checkOutput("gap_before_ready", g, DIV);
    waitDrain();

    $display("[TB] two chained bytes on ss2");
    rise0 = sck_rise;
    applyStimulus(2'd1, 8'h14, 1'b0, 8'h6E, 0);
    watch_ss2 = 1'b1;
    applyStimulus(2'($urandom_range(0, 3)), 8'hFF, 1'b1, 8'hC1, 0);
    waitRises(rise0 + 16);
    watch_ss2 = 1'b0;
    checkOutput("ss2_held_low", ss2_high, 32'd0);
    waitDrain();
    repeat (3) @(negedge clk);
    checkOutput("sck_rises_two_bytes", sck_rise - rise0, 32'd16);

    $display("[TB] abort after third SCK rise");
    applyStimulus(2'd2, 8'h3B, 1'b1, 8'h99, 0);
    waitRises(base_rise + 3);
    abort = 1'b1;
    void'(sb_q.pop_back());
    chain_open = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_sck", {31'd0, spi_sck}, 32'd0);
    checkOutput("abort_selects", {29'd0, spi_ss3, spi_ss2, conf_data0}, 32'h7);
    g = 0;
    while (tx_ready !== 1'b1 && g < 20) begin
      g++;
      @(negedge clk);
    end
    checkOutput("abort_gap", g, DIV);

    $display("[TB] reset during bit 5");
    applyStimulus(2'd1, 8'h5C, 1'b1, 8'h27, 0);
    waitRises(base_rise + 3);
    reset = 1'b1;
    void'(sb_q.pop_back());
    chain_open = 1'b0;
    @(negedge clk);
    checkOutput("midreset_sck", {31'd0, spi_sck}, 32'd0);
    checkOutput("midreset_selects", {29'd0, spi_ss3, spi_ss2, conf_data0}, 32'h7);
    checkOutput("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midreset_tx_ready", {31'd0, tx_ready}, 32'd1);
    applyStimulus(2'd0, 8'h81, 1'b1, 8'h42, 0);
    waitDrain();

    $display("[TB] random transactions");
    for (int i = 0; i < 20; i++) begin
      last_r = (i == 19) ? 1'b1 : ($urandom_range(0, 2) == 0);
      applyStimulus(2'($urandom_range(0, 3)), 8'($urandom), last_r, 8'($urandom),
                    int'($urandom_range(0, 30)));
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    waitDrain();

    $display("[TB] CLK_DIV=1 loopback");
    loopTest(8'h5A);
    for (int i = 0; i < 4; i++) loopTest(8'($urandom));

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
